mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- MEM-stage controller between the EX/MEM pipeline register and the MEM/WB pipeline register; replaces the single-cycle data memory path.
- Turns ex_mem load/store controls into a req/ack transaction to a variable-latency data memory port.
- Asserts mem_stall to freeze the PC, IF/ID, ID/EX and EX/MEM registers and to bubble MEM/WB until the access completes.
- Delivers load data to the writeback mux.

Parameters:
- ADDR_WIDTH, 32, byte address width of the memory port.
- DATA_WIDTH, 32, data word width.
- TIMEOUT_CYCLES, 16, maximum BUSY cycles without mem_ack before the access is aborted; legal range 2..255.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- ex_mem_mem_read  input  1  load in MEM stage.
- ex_mem_mem_write  input  1  store in MEM stage.
- ex_mem_alu_result  input  ADDR_WIDTH  effective address.
- ex_mem_alu_in2_out  input  DATA_WIDTH  store data.
- mem_stall  output  1  freeze upstream registers and insert a bubble into MEM/WB.
- mem_read_data  output  DATA_WIDTH  load result to the MEM/WB register.
- mem_err  output  1  one-cycle pulse: timeout, or read and write asserted together.
- mem_req  output  1  memory request, registered.
- mem_we  output  1  1 = write, registered.
- mem_addr  output  ADDR_WIDTH  registered address.
- mem_wdata  output  DATA_WIDTH  registered write data.
- mem_ack  input  1  memory completion, sampled only in BUSY.
- mem_rdata  input  DATA_WIDTH  valid when mem_ack=1 for a read.

Behaviour:
- Reset values, applied on reset at a clock edge:
  - state=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - mem_read_data=0, mem_err=0, timeout count=0.
- Reset mid-transaction: the next edge aborts the transaction. mem_req drops and mem_stall is 0 from that cycle on. A late mem_ack is ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - mem_stall = ex_mem_mem_read | ex_mem_mem_write (combinational).
  - If either is set: capture address, data and mem_we into the mem_* registers; mem_we=1 if ex_mem_mem_write is set; mem_req<=1; count<=0; go to BUSY.
  - If both are set: the write wins, and mem_err pulses on the next cycle.
- BUSY:
  - mem_stall=1; mem_req stays 1 and address/data stay stable.
  - On mem_ack=1: mem_req<=0; on a read, mem_read_data<=mem_rdata; go to DONE.
  - Without ack: count increments. If count==TIMEOUT_CYCLES-1 and there is no ack: mem_req<=0, mem_err<=1 for one cycle, mem_read_data<=0 on a read, go to DONE.
  - An ack on the timeout cycle counts as success.
- DONE:
  - mem_stall=0 for exactly one cycle, so the pipeline advances and MEM/WB captures mem_read_data.
  - Next state is IDLE unconditionally, so the same instruction is never reissued.
- Latency: at least 2 stall cycles per access (IDLE detect, then BUSY with an immediate ack). Non-memory instructions see 0 stall cycles.
- mem_read_data holds its value until the next read completes; writes and timed-out writes leave it unchanged.
- mem_ack outside BUSY is ignored.
- Back-to-back memory instructions: each pays the full IDLE→BUSY→DONE sequence.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- With the macro defined: if ex_mem_alu_result[1:0]!=0 in IDLE with a request pending, no mem_req is issued. The FSM goes directly to DONE (1 stall cycle), mem_err pulses, and a misaligned read returns 0.
- Without the macro: address bits [1:0] are passed through unchecked.

Decomposition:
- Shared package holds:
  - the state enum (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - the error read value constant (0);
  - the default TIMEOUT_CYCLES.
- Sub-module mem_timeout_counter holds the clear/enable/terminal-count logic, width $clog2(TIMEOUT_CYCLES).

Test Plan:
- Read at addr 0x10, ack on the first BUSY cycle with rdata 0xCAFEF00D → mem_stall high 2 cycles, mem_req 1 cycle, mem_read_data=0xCAFEF00D in DONE, mem_err=0.
- Write 0x12345678 to 0x20, ack after 5 BUSY cycles → mem_we=1, mem_addr/mem_wdata stable throughout, 6 stall cycles, mem_read_data unchanged.
- Read with no ack, TIMEOUT_CYCLES=16 → mem_req falls after 16 BUSY cycles, mem_err pulses once, mem_read_data=0, stall releases the following cycle.
- Reset asserted on the 3rd BUSY cycle, then a stray ack → state IDLE, mem_req=0, mem_stall=0, and the ack has no effect.
- Read and write asserted together, addr 0x8 → write issued (mem_we=1), mem_err pulses once.
- Under MEM_ALIGN_CHECK_EN, read at 0x13 → no mem_req, 1 stall cycle, mem_err=1, mem_read_data=0.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_pkg
//   Shared definitions for the MEM-stage memory access controller:
//     - state_e                 : controller FSM states (IDLE/BUSY/DONE)
//     - DEFAULT_TIMEOUT_CYCLES  : default BUSY-cycle budget before an abort
//     - ERR_READ_VALUE          : load result returned by a failed read
//     - is_misaligned()         : word-alignment test on the two address LSBs
// -----------------------------------------------------------------------------
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  // Wide enough for any realistic data path; users cast down to DATA_WIDTH.
  localparam logic [127:0] ERR_READ_VALUE = '0;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// -----------------------------------------------------------------------------
// mem_timeout_counter
//   Counts BUSY cycles spent waiting for mem_ack and flags the last permitted
//   cycle so the controller can abort the access.
//   Ports:
//     clk      in  pipeline clock
//     reset    in  synchronous active-high reset
//     clr      in  force the count to zero (controller not waiting)
//     en       in  advance the count by one (waiting, no ack this cycle)
//     terminal out count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module mem_timeout_counter
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic terminal
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign terminal = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !terminal) begin
      // Saturate at the terminal value; the controller leaves BUSY there.
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   MEM-stage controller. Converts the EX/MEM load/store controls into a
//   req/ack transaction on a variable-latency data memory port, stalls the
//   pipeline until the access completes, and presents load data to the
//   writeback mux. Every access walks IDLE -> BUSY -> DONE; DONE releases the
//   stall for exactly one cycle so the instruction retires once.
//
//   Optional feature: define MEM_ALIGN_CHECK_EN to reject word-misaligned
//   accesses (no memory request, one stall cycle, mem_err pulse, reads
//   return zero). Without it, address bits [1:0] pass through unchecked.
//
//   Ports:
//     clk, reset                 pipeline clock, synchronous active-high reset
//     ex_mem_mem_read/_write     load / store in the MEM stage
//     ex_mem_alu_result          effective byte address
//     ex_mem_alu_in2_out         store data
//     mem_stall                  freeze upstream, bubble MEM/WB
//     mem_read_data              load result (held until the next read ends)
//     mem_err                    one-cycle pulse: timeout, rd+wr, misaligned
//     mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//     mem_ack, mem_rdata         memory response (ack honoured only in BUSY)
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_mem_mem_read,
  input  logic                  ex_mem_mem_write,
  input  logic [ADDR_WIDTH-1:0] ex_mem_alu_result,
  input  logic [DATA_WIDTH-1:0] ex_mem_alu_in2_out,
  output logic                  mem_stall,
  output logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_READ_VALUE);

  state_e                state_q, state_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic                  err_q, err_d;

  logic access_req;
  logic misaligned;
  logic cnt_clr;
  logic cnt_en;
  logic cnt_terminal;

  assign access_req = ex_mem_mem_read | ex_mem_mem_write;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = is_misaligned(ex_mem_alu_result[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .terminal (cnt_terminal)
  );

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    err_d     = 1'b0;
    mem_stall = 1'b0;
    cnt_clr   = 1'b1;
    cnt_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Stall in the detect cycle itself so EX/MEM holds the instruction.
        mem_stall = access_req;
        if (access_req) begin
          if (misaligned) begin
            // Rejected without touching memory; retire through DONE.
            state_d = DONE;
            err_d   = 1'b1;
            if (!ex_mem_mem_write) begin
              rd_d = ERR_DATA;
            end
          end else begin
            state_d = BUSY;
            req_d   = 1'b1;
            // A simultaneous read+write is treated as a write and flagged.
            we_d    = ex_mem_mem_write;
            addr_d  = ex_mem_alu_result;
            wdata_d = ex_mem_alu_in2_out;
            err_d   = ex_mem_mem_read & ex_mem_mem_write;
          end
        end
      end

      BUSY: begin
        mem_stall = 1'b1;
        cnt_clr   = 1'b0;
        cnt_en    = !mem_ack;
        // Ack takes priority, so an ack on the final permitted cycle succeeds.
        if (mem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) begin
            rd_d = mem_rdata;
          end
        end else if (cnt_terminal) begin
          state_d = DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          if (!we_q) begin
            rd_d = ERR_DATA;
          end
        end
      end

      DONE: begin
        // One unstalled cycle lets the pipeline advance past this instruction.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  assign mem_req       = req_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_read_data = rd_q;
  assign mem_err       = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Self-checking bench for mem_access_ctrl. Each instruction is described by
//   its controls, address/data and the memory's ack latency (0 = never acks);
//   the bench acts as pipeline and memory, then compares stall cycles,
//   request cycles, request stability, error pulses and the delivered load
//   data against expectations from a fixed table, hand sequences, and a
//   transaction-level model for randomized instructions.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 16;

  typedef enum int {K_NONE, K_READ, K_WRITE, K_BOTH} kind_e;

  typedef struct {
    kind_e          kind;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    int             ack_lat;
    logic [DW-1:0]  rdata;
    int             exp_stall;
    int             exp_req;
    logic           exp_we;
    int             exp_err;
    logic [DW-1:0]  exp_rd;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_mem_mem_read;
  logic          ex_mem_mem_write;
  logic [AW-1:0] ex_mem_alu_result;
  logic [DW-1:0] ex_mem_alu_in2_out;
  logic          mem_stall;
  logic [DW-1:0] mem_read_data;
  logic          mem_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  int            n_vec  = 0;
  int            n_miss = 0;
  logic [DW-1:0] model_rd;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .ex_mem_mem_read    (ex_mem_mem_read),
    .ex_mem_mem_write   (ex_mem_mem_write),
    .ex_mem_alu_result  (ex_mem_alu_result),
    .ex_mem_alu_in2_out (ex_mem_alu_in2_out),
    .mem_stall          (mem_stall),
    .mem_read_data      (mem_read_data),
    .mem_err            (mem_err),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_ack            (mem_ack),
    .mem_rdata          (mem_rdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input kind_e k, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input int lat, input logic [DW-1:0] rdv, input int st, input int rq,
                              input logic we, input int er, input logic [DW-1:0] rd);
    vec_t v;
    v.kind = k; v.addr = a; v.wdata = wd; v.ack_lat = lat; v.rdata = rdv;
    v.exp_stall = st; v.exp_req = rq; v.exp_we = we; v.exp_err = er; v.exp_rd = rd;
    return v;
  endfunction

  // Transaction-level reference: outcome of one instruction from the rules.
  function automatic vec_t predict(input kind_e k, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                   input int lat, input logic [DW-1:0] rdv, input logic [DW-1:0] prev_rd);
    vec_t v;
    bit   is_mem, is_rd_only, is_wr, mis, acked;
    is_mem     = (k != K_NONE);
    is_rd_only = (k == K_READ);
    is_wr      = (k == K_WRITE) || (k == K_BOTH);
    mis        = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis        = is_mem && (a[1:0] != 2'b00);
`endif
    acked      = (lat >= 1) && (lat <= T);
    v = mk(k, a, wd, lat, rdv, 0, 0, is_wr, 0, prev_rd);
    if (is_mem && mis) begin
      v.exp_stall = 1;
      v.exp_err   = 1;
      if (is_rd_only) v.exp_rd = '0;
    end else if (is_mem) begin
      v.exp_req   = acked ? lat : T;
      v.exp_stall = 1 + v.exp_req;
      v.exp_err   = ((k == K_BOTH) ? 1 : 0) + (acked ? 0 : 1);
      if (is_rd_only) v.exp_rd = acked ? rdv : '0;
    end
    return v;
  endfunction

  // Entered just after a falling edge; returns just after a falling edge.
  task automatic run_txn(input vec_t v, input string tag);
    int            busy = 0, stalls = 0, reqs = 0, errs = 0, unstable = 0, cyc = 0;
    bit            done = 1'b0;
    logic [DW-1:0] rd_at_done = '0;
    ex_mem_mem_read    = (v.kind == K_READ)  || (v.kind == K_BOTH);
    ex_mem_mem_write   = (v.kind == K_WRITE) || (v.kind == K_BOTH);
    ex_mem_alu_result  = v.addr;
    ex_mem_alu_in2_out = v.wdata;
    while (!done && cyc < 300) begin
      #1;
      if (mem_stall) stalls++;
      if (mem_err)   errs++;
      if (mem_req) begin
        reqs++;
        busy++;
        if (mem_addr !== v.addr || mem_we !== v.exp_we || (v.exp_we && mem_wdata !== v.wdata))
          unstable++;
        mem_ack   = (busy == v.ack_lat);
        mem_rdata = (busy == v.ack_lat) ? v.rdata : $urandom();
      end else begin
        // Stray acks while no request is outstanding must be ignored.
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom();
      end
      if (!mem_stall) begin
        done       = 1'b1;
        rd_at_done = mem_read_data;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, " completes"}, 64'(done), 64'd1);
    check({tag, " stall_cycles"}, 64'(stalls), 64'(v.exp_stall));
    check({tag, " req_cycles"}, 64'(reqs), 64'(v.exp_req));
    check({tag, " req_stable"}, 64'(unstable), 64'd0);
    check({tag, " err_pulses"}, 64'(errs), 64'(v.exp_err));
    check({tag, " read_data"}, 64'(rd_at_done), 64'(v.exp_rd));
    model_rd = v.exp_rd;
  endtask

  vec_t table_v[8];

  initial begin
    reset = 1'b1; ex_mem_mem_read = 1'b0; ex_mem_mem_write = 1'b0;
    ex_mem_alu_result = '0; ex_mem_alu_in2_out = '0; mem_ack = 1'b0; mem_rdata = '0;
    model_rd = '0;

    table_v[0] = mk(K_READ,  32'h10, 32'h0,        1,  32'hCAFEF00D, 2,  1,  1'b0, 0, 32'hCAFEF00D);
    table_v[1] = mk(K_WRITE, 32'h20, 32'h12345678, 5,  32'hDEADBEEF, 6,  5,  1'b1, 0, 32'hCAFEF00D);
    table_v[2] = mk(K_READ,  32'h40, 32'h0,        0,  32'h11111111, 17, 16, 1'b0, 1, 32'h0);
    table_v[3] = mk(K_BOTH,  32'h08, 32'hA5A5A5A5, 2,  32'h22222222, 3,  2,  1'b1, 1, 32'h0);
    table_v[4] = mk(K_NONE,  32'h50, 32'h0,        1,  32'h33333333, 0,  0,  1'b0, 0, 32'h0);
    table_v[5] = mk(K_READ,  32'h44, 32'h0,        16, 32'h13572468, 17, 16, 1'b0, 0, 32'h13572468);
    table_v[6] = mk(K_WRITE, 32'h48, 32'h0F0F0F0F, 17, 32'h44444444, 17, 16, 1'b1, 1, 32'h13572468);
`ifdef MEM_ALIGN_CHECK_EN
    table_v[7] = mk(K_READ,  32'h13, 32'h0,        3,  32'h55AA55AA, 1,  0,  1'b0, 1, 32'h0);
`else
    table_v[7] = mk(K_READ,  32'h13, 32'h0,        3,  32'h55AA55AA, 4,  3,  1'b0, 0, 32'h55AA55AA);
`endif

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    check("reset mem_req",       64'(mem_req),       64'd0);
    check("reset mem_we",        64'(mem_we),        64'd0);
    check("reset mem_addr",      64'(mem_addr),      64'd0);
    check("reset mem_wdata",     64'(mem_wdata),     64'd0);
    check("reset mem_read_data", 64'(mem_read_data), 64'd0);
    check("reset mem_err",       64'(mem_err),       64'd0);
    check("reset mem_stall",     64'(mem_stall),     64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_txn(table_v[i], $sformatf("table[%0d]", i));
    end

    // Reset on the 3rd BUSY cycle, then stray acks.
    begin
      int busy = 0;
      ex_mem_mem_read = 1'b1; ex_mem_mem_write = 1'b0; ex_mem_alu_result = 32'h30;
      mem_ack = 1'b0;
      for (int c = 0; c < 10 && busy < 3; c++) begin
        #1;
        if (mem_req) busy++;
        if (busy < 3) @(negedge clk);
      end
      check("midreset reached busy3", 64'(busy), 64'd3);
      reset = 1'b1; ex_mem_mem_read = 1'b0;
      @(negedge clk);
      #1;
      check("midreset mem_req",   64'(mem_req),   64'd0);
      check("midreset mem_stall", 64'(mem_stall), 64'd0);
      reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        #1;
        check($sformatf("stray ack[%0d] mem_req", c),   64'(mem_req),       64'd0);
        check($sformatf("stray ack[%0d] mem_stall", c), 64'(mem_stall),     64'd0);
        check($sformatf("stray ack[%0d] read_data", c), 64'(mem_read_data), 64'd0);
        check($sformatf("stray ack[%0d] mem_err", c),   64'(mem_err),       64'd0);
      end
      mem_ack = 1'b0;
      @(negedge clk);
      model_rd = '0;
      run_txn(predict(K_READ, 32'h34, 32'h0, 1, 32'h600DCAFE, model_rd), "post-reset read");
    end

    // Randomized instruction stream against the transaction model.
    for (int i = 0; i < 40; i++) begin
      kind_e         k;
      logic [AW-1:0] a;
      int            r, lat;
      k = kind_e'($urandom_range(0, 3));
      a = $urandom();
      r = $urandom_range(0, 9);
      if (r == 0)      lat = 0;
      else if (r == 1) lat = $urandom_range(T - 1, T + 1);
      else             lat = $urandom_range(1, 5);
      run_txn(predict(k, a, $urandom(), lat, $urandom(), model_rd), $sformatf("rand[%0d]", i));
    end

    ex_mem_mem_read = 1'b0; ex_mem_mem_write = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
